writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of cycles to wait for load data (range 1..255).
REQ-002 Parameter CNT_W, default 16: width of the retire counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port ex_valid  input  1  execute stage presents a completed instruction.
REQ-006 Port ex_ready  output  1  writeback can accept an instruction this cycle.
REQ-007 Port ex_wen  input  1  instruction writes a register.
REQ-008 Port ex_is_load  input  1  result comes from memory, not from ex_result.
REQ-009 Port ex_rd  input  3  destination register index.
REQ-010 Port ex_result  input  8  ALU result.
REQ-011 Port mem_rvalid  input  1  load data valid this cycle.
REQ-012 Port mem_rdata  input  8  load data.
REQ-013 Port rf_we  output  1  register-file write enable.
REQ-014 Port rf_waddr  output  3  register-file write address.
REQ-015 Port rf_wdata  output  8  register-file write data.
REQ-016 Port retired  output  CNT_W  count of completed instructions.
REQ-017 Port load_err  output  1  sticky flag: a load timed out.

Function
REQ-018 The FSM SHALL have two states: RUN and WAIT_LOAD.
REQ-019 ex_ready SHALL be 1 in RUN and 0 in WAIT_LOAD; it is a combinational decode of the state.
REQ-020 An instruction is accepted when ex_valid=1 and ex_ready=1.
REQ-021 Accepting a non-load SHALL drive rf_we=ex_wen, rf_waddr=ex_rd, rf_wdata=ex_result in the next cycle, for exactly one cycle.
REQ-022 RUN SHALL sustain one accept per cycle, so back-to-back non-loads give back-to-back writes.
REQ-023 Accepting a load SHALL capture ex_rd and ex_wen and move the FSM to WAIT_LOAD; rf_we SHALL be 0 in the following cycle.
REQ-024 In WAIT_LOAD, mem_rvalid=1 SHALL drive rf_we=captured wen, rf_waddr=captured rd, rf_wdata=mem_rdata in the next cycle, and return the FSM to RUN.
REQ-025 mem_rvalid SHALL be ignored in RUN, including the cycle in which a load is accepted.
REQ-026 When rf_we=0, rf_waddr and rf_wdata SHALL hold their previous values.
REQ-027 retired SHALL increment by 1 on each completed instruction, whether or not it writes, in the same cycle rf_we would be driven; it wraps modulo 2^CNT_W.
REQ-028 Writes to index 0 SHALL be treated like writes to any other index.

Reset
REQ-029 rst_n=0 SHALL immediately set the FSM to RUN and clear rf_we, rf_waddr, rf_wdata, retired, load_err and the timeout counter.
REQ-030 A reset while in WAIT_LOAD SHALL discard the pending load; no write is issued afterwards.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro WB_LOAD_TIMEOUT_EN selects load-timeout handling.
REQ-033 With WB_LOAD_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT_LOAD and increment each cycle that mem_rvalid=0. On the cycle the count reaches TIMEOUT, the FSM SHALL return to RUN with no write, retired SHALL increment, and load_err SHALL set and stay set until reset. mem_rvalid in that same cycle SHALL win: the write is issued and no error is raised.
REQ-034 With WB_LOAD_TIMEOUT_EN undefined, WAIT_LOAD SHALL wait indefinitely, load_err SHALL be tied 0, and no timeout counter SHALL be synthesised.

Verification
REQ-035 Reset then non-load ex_rd=3, ex_result=0x5A, ex_wen=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x5A; retired=1.
REQ-036 Three consecutive non-loads to R1, R2, R3 with data 0x11, 0x22, 0x33 -> three consecutive rf_we pulses in order; ex_ready stays 1; retired=3.
REQ-037 Load to R5 with mem_rvalid=1 asserted 4 cycles later, mem_rdata=0xC3 -> ex_ready=0 for 4 cycles, then rf_we=1, rf_waddr=5, rf_wdata=0xC3 one cycle after mem_rvalid; ex_ready returns to 1.
REQ-038 Non-load with ex_wen=0 -> rf_we stays 0 and retired increments.
REQ-039 Load accepted, rst_n pulsed low 2 cycles later, then mem_rvalid=1 after release -> no write; all outputs 0; FSM in RUN.
REQ-040 With WB_LOAD_TIMEOUT_EN and TIMEOUT=15, load accepted with no mem_rvalid -> after 15 cycles load_err=1, no write, ex_ready=1; a subsequent non-load writes normally and load_err remains 1.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: last pipeline stage. Retires execute-stage instructions into
// the register file and stalls the execute stage while a load's data is
// outstanding. Optional load-timeout handling is enabled by defining
// WB_LOAD_TIMEOUT_EN; without it a pending load waits indefinitely.
module writeback_stage #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_wen,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_rd,
  input  logic [7:0]       ex_result,
  input  logic             mem_rvalid,
  input  logic [7:0]       mem_rdata,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [7:0]       rf_wdata,
  output logic [CNT_W-1:0] retired,
  output logic             load_err
);

  // The timeout counter is 8 bits wide, so TIMEOUT must fit in 1..255.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("writeback_stage: TIMEOUT must be in 1..255");
  end

  typedef enum logic {RUN = 1'b0, WAIT_LOAD = 1'b1} state_t;

  state_t           state_reg,    state_next;
  logic             cap_wen_reg,  cap_wen_next;
  logic [2:0]       cap_rd_reg,   cap_rd_next;
  logic             rf_we_reg,    rf_we_next;
  logic [2:0]       rf_waddr_reg, rf_waddr_next;
  logic [7:0]       rf_wdata_reg, rf_wdata_next;
  logic [CNT_W-1:0] retired_reg,  retired_next;
  logic             accept;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
  logic [7:0] tcnt_reg, tcnt_next;
  logic       load_err_reg, load_err_next;
`endif

  assign ex_ready = (state_reg == RUN);
  assign accept   = ex_valid & ex_ready;

  // Next-state and datapath decode; address/data only move when a write happens.
  always_comb begin
    state_next    = state_reg;
    cap_wen_next  = cap_wen_reg;
    cap_rd_next   = cap_rd_reg;
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    retired_next  = retired_reg;
`ifdef WB_LOAD_TIMEOUT_EN
    tcnt_next     = tcnt_reg;
    load_err_next = load_err_reg;
`endif
    case (state_reg)
      RUN: begin
        if (accept) begin
          if (ex_is_load) begin
            cap_wen_next = ex_wen;
            cap_rd_next  = ex_rd;
            state_next   = WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
            tcnt_next    = 8'd0;
`endif
          end else begin
            rf_we_next   = ex_wen;
            retired_next = retired_reg + CNT_W'(1);
            if (ex_wen) begin
              rf_waddr_next = ex_rd;
              rf_wdata_next = ex_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          rf_we_next   = cap_wen_reg;
          retired_next = retired_reg + CNT_W'(1);
          state_next   = RUN;
          if (cap_wen_reg) begin
            rf_waddr_next = cap_rd_reg;
            rf_wdata_next = mem_rdata;
          end
        end else begin
`ifdef WB_LOAD_TIMEOUT_EN
          tcnt_next = tcnt_reg + 8'd1;
          // Give up on the load: it still counts as retired, but flags an error.
          if (tcnt_reg + 8'd1 == TIMEOUT_LIM) begin
            state_next    = RUN;
            retired_next  = retired_reg + CNT_W'(1);
            load_err_next = 1'b1;
          end
`endif
        end
      end
      default: state_next = RUN;
    endcase
  end

  // FSM state register; reset forces RUN, dropping any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: captured load destination, write port and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_wen_reg  <= 1'b0;
      cap_rd_reg   <= 3'd0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= 3'd0;
      rf_wdata_reg <= 8'd0;
      retired_reg  <= '0;
    end else begin
      cap_wen_reg  <= cap_wen_next;
      cap_rd_reg   <= cap_rd_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      retired_reg  <= retired_next;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_reg     <= 8'd0;
      load_err_reg <= 1'b0;
    end else begin
      tcnt_reg     <= tcnt_next;
      load_err_reg <= load_err_next;
    end
  end

  assign load_err = load_err_reg;
`else
  assign load_err = 1'b0;
`endif

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign retired  = retired_reg;

endmodule
